// File: rtl/emu_pkg.sv
// emu_pkg: output-state layout and frame constants shared with the emulator-side decoder
//   STATE_LEN, field offsets, frame header/length, FSM state type, byte/checksum helpers
package emu_pkg;
    localparam int STATE_LEN = 52;
    localparam int PAD_LEN = 56;
    localparam int LED_LSB = 0;
    localparam int HEX0_LSB = 10;
    localparam int HEX_STEP = 7;
    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    localparam int FRAME_BYTES = 9;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    function automatic logic [7:0] pad_byte(input logic [PAD_LEN-1:0] pad, input logic [3:0] k);
        return 8'(pad >> {k, 3'b000});
    endfunction

    // Checksum covers the seven data bytes only; the header is excluded
    function automatic logic [7:0] frame_csum(input logic [PAD_LEN-1:0] pad);
        logic [7:0] c;
        c = '0;
        for (int k = 0; k < FRAME_BYTES - 2; k++) c = c ^ pad_byte(pad, 4'(k));
        return c;
    endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART byte transmitter with valid/ready handshake
//   CLK, RST_N (sync, active-low), DATA[7:0]/VALID in, READY out, TX out (idle high)
module uart_byte_tx #(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    output logic       TX
);
    localparam int CW = $clog2(DIV);

    logic [8:0]    r_sh;
    logic [3:0]    r_bit;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_tx;

    // Ready already in the final stop-bit clock so the next start bit follows without a gap
    assign READY = !r_busy || (r_bit == 4'd9 && r_cnt == CW'(DIV - 1));
    assign TX = r_tx;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_busy <= 1'b0;
            r_tx <= 1'b1;
            r_bit <= '0;
            r_cnt <= '0;
            r_sh <= '1;
        end else if (VALID && READY) begin
            r_busy <= 1'b1;
            r_tx <= 1'b0;
            r_sh <= {1'b1, DATA};
            r_bit <= '0;
            r_cnt <= '0;
        end else if (r_busy) begin
            if (r_cnt == CW'(DIV - 1)) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    r_tx <= r_sh[0];
                    r_sh <= {1'b1, r_sh[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/emu_state_reporter.sv
// emu_state_reporter: serializes the 52-bit output-state vector to the host on change
//   CLK, RST_N (sync, active-low), STATE_IN[51:0], FORCE_SEND in; TX (8N1), BUSY out
//   Frame: HEADER, D0..D6 (padded state, LSB byte first), XOR checksum of D0..D6
module emu_state_reporter
    import emu_pkg::*;
#(
    parameter int         CLK_HZ = 50000000,
    parameter int         BAUD = 115200,
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [STATE_LEN-1:0] STATE_IN,
    input  logic                 FORCE_SEND,
    output logic                 TX,
    output logic                 BUSY
);
    localparam int DIV = CLK_HZ / BAUD;
    // Clocks after the checksum byte is accepted until BUSY drops in its last stop-bit clock
    localparam int TAIL = 10 * DIV - 1;
    localparam int TW = $clog2(TAIL + 1);

    state_t               r_state;
    logic [STATE_LEN-1:0] r_snap;
    logic [STATE_LEN-1:0] r_last;
    logic                 r_pend;
    logic                 r_busy;
    logic [7:0]           r_csum;
    logic [3:0]           r_idx;
    logic [TW-1:0]        r_tmr;
    logic [PAD_LEN-1:0]   w_pad;
    logic                 w_valid;
    logic                 w_ready;
    logic [7:0]           w_data;

    assign w_pad = {{(PAD_LEN - STATE_LEN){1'b0}}, r_snap};
    assign w_valid = r_state == S_LOAD || (r_state == S_SEND && r_idx < 4'(FRAME_BYTES));
    // r_idx 1..7 selects D0..D6, the last index selects the checksum
    assign w_data = r_state == S_LOAD ? HEADER :
                    r_idx == 4'(FRAME_BYTES - 1) ? r_csum : pad_byte(w_pad, r_idx - 4'd1);
    assign BUSY = r_busy;

    uart_byte_tx #(.DIV(DIV)) u_tx (
        .CLK  (CLK),
        .RST_N(RST_N),
        .DATA (w_data),
        .VALID(w_valid),
        .READY(w_ready),
        .TX   (TX)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_snap <= '0;
            r_last <= '0;
            r_pend <= 1'b1;
            r_busy <= 1'b0;
            r_csum <= '0;
            r_idx <= '0;
            r_tmr <= '0;
        end else begin
            if (FORCE_SEND && r_state != S_IDLE) r_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (STATE_IN != r_last || r_pend || FORCE_SEND) begin
                        r_snap <= STATE_IN;
                        r_last <= STATE_IN;
                        r_pend <= 1'b0;
                        r_busy <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_csum <= frame_csum(w_pad);
                    if (w_ready) begin
                        r_idx <= 4'd1;
                        r_state <= S_SEND;
                    end
                end
                default: begin
                    if (r_idx < 4'(FRAME_BYTES)) begin
                        if (w_ready) begin
                            r_idx <= r_idx + 4'd1;
                            r_tmr <= '0;
                        end
                    end else if (r_tmr == TW'(TAIL - 1)) begin
                        r_busy <= 1'b0;
                        r_idx <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
